gb_host: RTL

- Bus initiator (host end) for the ghostbus local bus.
- Accepts single-word read/write commands on a valid/ready command port and drives the bus strobes, address and write data.
- Captures read data after a fixed read latency and returns it on a valid/ready response port.
- Sits at the top of a ghostbus tree, above interposers and peripherals; the downstream fan-out is unchanged.

---
 rtl/gb_host.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gb_host.sv
// gb_host: ghostbus initiator; one single-word read/write command in flight at a time.
// Latency: strobe one cycle after accept; read data returned RD_LAT+1 cycles after the strobe edge.
// Backpressure: cmd_ready only in IDLE; the response holds until rsp_ready. GB_HOST_WACK_EN adds write acks.
module gb_host #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_is_wr,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_din
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LAT_M1 = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] gb_addr_q, gb_addr_d;
    logic [DW-1:0] gb_dout_q, gb_dout_d;
    logic          gb_we_q, gb_we_d;
    logic          gb_re_q, gb_re_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef GB_HOST_WACK_EN
    logic          rsp_is_wr_q, rsp_is_wr_d;
`endif

    // Ready depends only on registered state and reset, never on cmd_valid.
    assign cmd_ready = (state_q == S_IDLE) && rst_n;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gb_addr_d   = gb_addr_q;
        gb_dout_d   = gb_dout_q;
        gb_we_d     = 1'b0;
        gb_re_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef GB_HOST_WACK_EN
        rsp_is_wr_d = rsp_is_wr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    gb_addr_d = cmd_addr;
                    if (cmd_we) begin
                        gb_dout_d = cmd_wdata;
                    end
                    gb_we_d = cmd_we;
                    gb_re_d = !cmd_we;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (gb_we_q) begin
`ifdef GB_HOST_WACK_EN
                    rsp_valid_d = 1'b1;
                    rsp_is_wr_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
`else
                    state_d     = S_IDLE;
`endif
                end else begin
                    // A zero count samples on the very next edge, which covers RD_LAT==1.
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = gb_din;
                    rsp_valid_d = 1'b1;
`ifdef GB_HOST_WACK_EN
                    rsp_is_wr_d = 1'b0;
`endif
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gb_addr_q   <= '0;
            gb_dout_q   <= '0;
            gb_we_q     <= 1'b0;
            gb_re_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gb_addr_q   <= gb_addr_d;
            gb_dout_q   <= gb_dout_d;
            gb_we_q     <= gb_we_d;
            gb_re_q     <= gb_re_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef GB_HOST_WACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_is_wr_q <= 1'b0;
        end else begin
            rsp_is_wr_q <= rsp_is_wr_d;
        end
    end

    assign rsp_is_wr = rsp_is_wr_q;
`else
    assign rsp_is_wr = 1'b0;
`endif

    assign gb_addr   = gb_addr_q;
    assign gb_dout   = gb_dout_q;
    assign gb_we     = gb_we_q;
    assign gb_re     = gb_re_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
